// File: rtl/bus_pkg.sv
// bus_pkg: shared definitions for the system memory-mapped bus.
//   - bus widths, SPART base word address
//   - bus response codes, bus_master_port FSM states
package bus_pkg;

  localparam int unsigned BUS_ADDR_W = 30;
  localparam int unsigned BUS_DATA_W = 32;

  localparam logic [BUS_ADDR_W-1:0] SPART_BASE_ADDR = 30'h3E00000;

  // Status reported on rsp_status when a transaction is aborted by timeout.
  localparam logic [1:0] TIMEOUT_STATUS = 2'b11;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } bus_resp_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
  } bm_state_e;

endpackage

// File: rtl/bus_master_port_if.sv
// bus_master_port_if: memory-mapped bus signals between an initiator and
// the bus fabric / responder.
//   master modport: drives m_burstcount, m_address, m_writedata,
//                   m_byteenable, m_read, m_write; receives m_waitrequest,
//                   m_readdata, m_readdatavalid, m_writeresponsevalid,
//                   m_response.
//   slave modport:  the mirror image.
interface bus_master_port_if;
  import bus_pkg::*;

  logic [4:0]            m_burstcount;
  logic [BUS_ADDR_W-1:0] m_address;
  logic [BUS_DATA_W-1:0] m_writedata;
  logic [3:0]            m_byteenable;
  logic                  m_read;
  logic                  m_write;
  logic                  m_waitrequest;
  logic [BUS_DATA_W-1:0] m_readdata;
  logic                  m_readdatavalid;
  logic                  m_writeresponsevalid;
  logic [1:0]            m_response;

  modport master (
    output m_burstcount, m_address, m_writedata, m_byteenable, m_read, m_write,
    input  m_waitrequest, m_readdata, m_readdatavalid, m_writeresponsevalid,
           m_response
  );

  modport slave (
    input  m_burstcount, m_address, m_writedata, m_byteenable, m_read, m_write,
    output m_waitrequest, m_readdata, m_readdatavalid, m_writeresponsevalid,
           m_response
  );

endinterface

// File: rtl/bus_master_port.sv
// bus_master_port: single-outstanding bus initiator. Converts a
// command/response handshake into one read or write on the memory-mapped
// bus, honouring m_waitrequest and matching the response to the command.
//   clk, rst_n        : clock, asynchronous active-low reset
//   cmd_*             : command handshake (valid/ready, write, address,
//                       writedata, byteenable)
//   rsp_*             : response handshake (valid/ready, readdata, status,
//                       timeout flag)
//   busy              : FSM is not idle
//   m                 : bus_master_port_if.master (m_* bus signals)
// Optional feature macro BUS_MASTER_TIMEOUT_EN: aborts a transaction after
// TIMEOUT_CYCLES cycles in REQ/WAIT; without it the block waits forever and
// rsp_timeout is constant 0.
module bus_master_port
  import bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [BUS_ADDR_W-1:0] cmd_address,
  input  logic [BUS_DATA_W-1:0] cmd_writedata,
  input  logic [3:0]            cmd_byteenable,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [BUS_DATA_W-1:0] rsp_readdata,
  output logic [1:0]            rsp_status,
  output logic                  rsp_timeout,
  output logic                  busy,
  bus_master_port_if.master     m
);

  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_cfg_check
    $error("TIMEOUT_CYCLES must be in 1..65535");
  end

  bm_state_e state, state_nxt;

  logic                  cmd_take, bus_taken, rsp_capture, rsp_taken;
  logic                  tmo_hit, tmo_abort;
  logic                  req_write, req_rd, req_wr;
  logic [BUS_ADDR_W-1:0] req_addr;
  logic [BUS_DATA_W-1:0] req_wdata;
  logic [3:0]            req_be;

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

  assign m.m_burstcount = 5'd1;
  assign m.m_address    = req_addr;
  assign m.m_writedata  = req_wdata;
  assign m.m_byteenable = req_be;
  assign m.m_read       = req_rd;
  assign m.m_write      = req_wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Only the response type matching the outstanding command is honoured in
  // WAIT; anything seen in other states is simply not looked at.
  always_comb begin
    state_nxt   = state;
    cmd_take    = 1'b0;
    bus_taken   = 1'b0;
    rsp_capture = 1'b0;
    rsp_taken   = 1'b0;
    tmo_abort   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          cmd_take  = 1'b1;
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (tmo_hit) begin
          tmo_abort = 1'b1;
          state_nxt = ST_RESP;
        end else if (!m.m_waitrequest) begin
          bus_taken = 1'b1;
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (tmo_hit) begin
          tmo_abort = 1'b1;
          state_nxt = ST_RESP;
        end else if (req_write ? m.m_writeresponsevalid : m.m_readdatavalid) begin
          rsp_capture = 1'b1;
          state_nxt   = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_taken = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_addr     <= '0;
      req_wdata    <= '0;
      req_be       <= '0;
      req_write    <= 1'b0;
      req_rd       <= 1'b0;
      req_wr       <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_readdata <= '0;
      rsp_status   <= '0;
    end else begin
      if (cmd_take) begin
        req_addr  <= cmd_address;
        req_wdata <= cmd_writedata;
        req_be    <= cmd_byteenable;
        req_write <= cmd_write;
        req_rd    <= !cmd_write;
        req_wr    <= cmd_write;
      end
      if (bus_taken || tmo_abort) begin
        req_rd <= 1'b0;
        req_wr <= 1'b0;
      end
      if (rsp_capture) begin
        rsp_valid    <= 1'b1;
        rsp_status   <= m.m_response;
        rsp_readdata <= req_write ? '0 : m.m_readdata;
      end
      if (tmo_abort) begin
        rsp_valid    <= 1'b1;
        rsp_status   <= TIMEOUT_STATUS;
        rsp_readdata <= '0;
      end
      if (rsp_taken) rsp_valid <= 1'b0;
    end
  end

`ifdef BUS_MASTER_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] tmo_cnt;
  logic        tmo_flag;

  // tmo_cnt holds the number of cycles already spent in REQ/WAIT, so the
  // abort fires in the cycle that completes TIMEOUT_CYCLES.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   tmo_cnt <= '0;
    else if (cmd_take)                            tmo_cnt <= '0;
    else if (state == ST_REQ || state == ST_WAIT) tmo_cnt <= tmo_cnt + 16'd1;
  end

  assign tmo_hit = (state == ST_REQ || state == ST_WAIT) && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         tmo_flag <= 1'b0;
    else if (tmo_abort) tmo_flag <= 1'b1;
    else if (rsp_taken) tmo_flag <= 1'b0;
  end

  assign rsp_timeout = tmo_flag;
`else
  assign tmo_hit     = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_bus_master_port.sv
`timescale 1ns/1ps
module tb_bus_master_port;
  import bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [29:0] cmd_address = '0;
  logic [31:0] cmd_writedata = '0;
  logic [3:0]  cmd_byteenable = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_readdata;
  logic [1:0]  rsp_status;
  logic        rsp_timeout;
  logic        busy;

  bus_master_port_if bus();

  bus_master_port #(.TIMEOUT_CYCLES(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_write      (cmd_write),
    .cmd_address    (cmd_address),
    .cmd_writedata  (cmd_writedata),
    .cmd_byteenable (cmd_byteenable),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_readdata   (rsp_readdata),
    .rsp_status     (rsp_status),
    .rsp_timeout    (rsp_timeout),
    .busy           (busy),
    .m              (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] data;
    logic [1:0]  status;
    logic        tmo;
  } rsp_t;

  rsp_t exp_q[$];
  int   hs_cyc = 0;

  // rsp_ready changes only just after posedge, so at negedge valid&ready
  // means the handshake happens on the coming edge.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      hs_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("stray_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        check("rsp_readdata", rsp_readdata, e.data);
        check("rsp_status", 32'(rsp_status), 32'(e.status));
        check("rsp_timeout", 32'(rsp_timeout), 32'(e.tmo));
      end
    end
  end

  // ---------------- responder model ----------------
  int          stall_cfg = 0;
  int          resp_delay = 0;
  bit          resp_en = 1'b1;
  bit          stray_in_wait = 1'b0;
  bit          stray_now = 1'b0;
  logic [31:0] resp_data = '0;
  logic [1:0]  resp_code = 2'b00;

  initial begin : responder
    int   stall_left, pend_cnt;
    logic accept, was_read, pend_read;
    stall_left = 0; pend_cnt = 0; pend_read = 1'b0; accept = 1'b0; was_read = 1'b0;
    bus.m_waitrequest        = 1'b0;
    bus.m_readdatavalid      = 1'b0;
    bus.m_writeresponsevalid = 1'b0;
    bus.m_readdata           = '0;
    bus.m_response           = 2'b00;
    forever begin
      @(negedge clk);
      accept   = (bus.m_read || bus.m_write) && !bus.m_waitrequest;
      was_read = bus.m_read;
      if ((bus.m_read || bus.m_write) && bus.m_waitrequest && stall_left > 0) stall_left--;
      @(posedge clk); #1;
      if (!rst_n) begin accept = 1'b0; pend_cnt = 0; end
      bus.m_readdatavalid      = 1'b0;
      bus.m_writeresponsevalid = 1'b0;
      bus.m_readdata           = '0;
      bus.m_response           = 2'b00;
      if (accept && resp_en) begin
        pend_cnt  = resp_delay + 1;
        pend_read = was_read;
      end
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          if (pend_read) begin
            bus.m_readdatavalid = 1'b1;
            bus.m_readdata      = resp_data;
          end else begin
            bus.m_writeresponsevalid = 1'b1;
          end
          bus.m_response = resp_code;
        end else if (stray_in_wait && !pend_read) begin
          bus.m_readdatavalid = 1'b1;
          bus.m_readdata      = 32'hDEAD_BEEF;
          bus.m_response      = 2'b10;
        end
      end
      if (stray_now) begin
        bus.m_readdatavalid = 1'b1;
        bus.m_readdata      = 32'hBAD0_0001;
        bus.m_response      = 2'b10;
      end
      if (!(bus.m_read || bus.m_write)) stall_left = stall_cfg;
      bus.m_waitrequest = (stall_left > 0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue(input logic wr, input logic [29:0] a, input logic [31:0] d,
                       input logic [3:0] be, input bit expect_rsp, input rsp_t e,
                       output int acc_cyc);
    int n;
    if (expect_rsp) exp_q.push_back(e);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = wr; cmd_address = a;
    cmd_writedata = d; cmd_byteenable = be;
    n = 0;
    acc_cyc = 0;
    forever begin
      @(negedge clk);
      if (cmd_ready) begin acc_cyc = cyc; break; end
      n++;
      if (n > 200) begin check("cmd_accept_bound", 32'(cmd_ready), 32'd1); break; end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = '0;
    cmd_writedata = '0; cmd_byteenable = '0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic stray_pulse();
    @(posedge clk); #2 stray_now = 1'b1;
    @(posedge clk); #2 stray_now = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    rsp_t e;
    int   a1, a2, n, seen;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
    check("rst_m_read", 32'(bus.m_read), 32'd0);
    check("rst_m_write", 32'(bus.m_write), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_readdata", rsp_readdata, 32'd0);
    check("rst_rsp_status", 32'(rsp_status), 32'd0);
    check("rst_m_address", 32'(bus.m_address), 32'd0);
    check("rst_m_writedata", bus.m_writedata, 32'd0);
    check("rst_m_byteenable", 32'(bus.m_byteenable), 32'd0);
    check("rst_m_burstcount", 32'(bus.m_burstcount), 32'd1);
    @(posedge clk); #1 rst_n = 1'b1;

    // 1: SPART-style reads back-to-back, rsp_ready tied high
    rsp_ready = 1'b1;
    resp_data = 32'h0100_0000;
    resp_code = 2'b00;
    e = '{data: 32'h0100_0000, status: 2'b00, tmo: 1'b0};
    issue(1'b0, 30'h3E00010, 32'h0, 4'hF, 1'b1, e, a1);
    issue(1'b0, SPART_BASE_ADDR + 30'd1, 32'h0, 4'hF, 1'b1, e, a2);
    check("b2b_spacing", 32'(a2 - a1), 32'd4);
    drain("t1");

    // 2: write with waitrequest held 3 cycles, SLVERR response
    stall_cfg = 3;
    resp_code = 2'b10;
    repeat (2) @(negedge clk);
    e = '{data: 32'h0, status: 2'b10, tmo: 1'b0};
    fork
      issue(1'b1, 30'h3E00011, 32'h4100_0000, 4'h8, 1'b1, e, a1);
      begin : wr_watch
        int hi;
        hi = 0;
        for (int i = 0; i < 30; i++) begin
          @(negedge clk);
          if (bus.m_write) begin
            hi++;
            check("wr_address", 32'(bus.m_address), 32'h3E00011);
            check("wr_writedata", bus.m_writedata, 32'h4100_0000);
            check("wr_byteenable", 32'(bus.m_byteenable), 32'h8);
            check("wr_no_read", 32'(bus.m_read), 32'd0);
          end
        end
        check("wr_high_cycles", 32'(hi), 32'd4);
      end
    join
    drain("t2");
    stall_cfg = 0;
    resp_code = 2'b00;

    // 3: response back-pressure for 5 cycles
    @(posedge clk); #1 rsp_ready = 1'b0;
    resp_data = 32'hCAFE_0042;
    e = '{data: 32'hCAFE_0042, status: 2'b00, tmo: 1'b0};
    issue(1'b0, 30'h3E00012, 32'h0, 4'hF, 1'b1, e, a1);
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    check("bp_rsp_valid_seen", 32'(rsp_valid), 32'd1);
    resp_data = 32'h1234_5678;
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid_held", 32'(rsp_valid), 32'd1);
      check("bp_readdata_held", rsp_readdata, 32'hCAFE_0042);
      check("bp_cmd_ready_low", 32'(cmd_ready), 32'd0);
      @(negedge clk);
    end
    e = '{data: 32'h1234_5678, status: 2'b00, tmo: 1'b0};
    fork
      issue(1'b0, 30'h3E00013, 32'h0, 4'hF, 1'b1, e, a2);
      begin
        repeat (2) begin
          @(negedge clk);
          check("bp_cmd_blocked", 32'(cmd_ready), 32'd0);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
      end
    join
    check("bp_accept_after_hs", 32'(a2), 32'(hs_cyc + 1));
    drain("t3");

    // 4: stray read-data pulses in IDLE and during a write's WAIT
    stray_pulse();
    repeat (3) @(negedge clk);
    check("stray_idle_busy", 32'(busy), 32'd0);
    check("stray_idle_rsp_valid", 32'(rsp_valid), 32'd0);
    stray_in_wait = 1'b1;
    resp_delay = 3;
    e = '{data: 32'h0, status: 2'b00, tmo: 1'b0};
    issue(1'b1, 30'h3E00014, 32'h5A5A_A5A5, 4'h3, 1'b1, e, a1);
    drain("t4");
    stray_in_wait = 1'b0;
    resp_delay = 0;

`ifdef BUS_MASTER_TIMEOUT_EN
    // 5: responder never answers; later late response is ignored
    resp_en = 1'b0;
    e = '{data: 32'h0, status: 2'b11, tmo: 1'b1};
    issue(1'b0, 30'h3E00015, 32'h0, 4'hF, 1'b1, e, a1);
    drain("t5");
    stray_pulse();
    repeat (3) @(negedge clk);
    check("late_rsp_busy", 32'(busy), 32'd0);
    check("late_rsp_valid", 32'(rsp_valid), 32'd0);
    resp_en = 1'b1;
`endif

    // 6: reset asserted during WAIT
    resp_en = 1'b0;
    e = '{data: 32'h0, status: 2'b00, tmo: 1'b0};
    issue(1'b0, 30'h3E00016, 32'h0, 4'hF, 1'b0, e, a1);
    n = 0;
    while (!(busy && !bus.m_read && !bus.m_write) && n < 20) begin @(negedge clk); n++; end
    check("rw_reached_wait", 32'(busy && !bus.m_read && !bus.m_write), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rw_m_read", 32'(bus.m_read), 32'd0);
    check("rw_m_write", 32'(bus.m_write), 32'd0);
    check("rw_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rw_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rw_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    resp_en = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("rw_no_rsp_after_release", 32'(seen), 32'd0);

    repeat (3) @(negedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/bus_master_port.md
# bus_master_port

Single-outstanding bus initiator that turns a simple command/response handshake into read and write transactions on the system memory-mapped bus. It drives the same bus that peripheral responders such as the SPART decode. It sits between a command source (debug loader, boot sequencer or console poller) and the bus fabric. It handles `m_waitrequest` back-pressure, matches each request to its response, and optionally aborts hung transactions.

## Interface
- `TIMEOUT_CYCLES`, default 255: cycles allowed from request issue to response before abort (only with `BUS_MASTER_TIMEOUT_EN`).
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: a command is presented.
- `cmd_ready` out 1: the block accepts a command this cycle.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_address` in 30: word address.
- `cmd_writedata` in 32: write data.
- `cmd_byteenable` in 4: byte lanes.
- `rsp_valid` out 1: a response is held for the consumer.
- `rsp_ready` in 1: the consumer takes the response.
- `rsp_readdata` out 32: read data; 0 for writes.
- `rsp_status` out 2: the bus `m_response` value, or 2'b11 on timeout.
- `rsp_timeout` out 1: the response was produced by a timeout.
- `m_burstcount` out 5: constant 5'd1.
- `m_address` out 30: bus address.
- `m_writedata` out 32: bus write data.
- `m_byteenable` out 4: bus byte enables.
- `m_read` out 1: read request.
- `m_write` out 1: write request.
- `m_waitrequest` in 1: responder stall.
- `m_readdata` in 32: responder read data.
- `m_readdatavalid` in 1: read data valid.
- `m_writeresponsevalid` in 1: write response valid.
- `m_response` in 2: responder status.
- `busy` out 1: the state is not IDLE.

## Operation
- FSM states:
  - IDLE: `cmd_ready`=1. On `cmd_valid` the command is latched into the request registers; go to REQ.
  - REQ: `m_read` or `m_write` asserted, with address, data and byteenable held stable. If `m_waitrequest`=0 in a cycle, the request is accepted; go to WAIT. Otherwise stay.
  - WAIT: `m_read`/`m_write` low. For a read, `m_readdatavalid`=1 captures `m_readdata` and `m_response`. For a write, `m_writeresponsevalid`=1 captures `m_response` and `rsp_readdata` becomes 0. Either case goes to RESP. The response valid that does not match the command type is ignored.
  - RESP: `rsp_valid`=1 and the response registers are stable. `rsp_ready`=1 returns to IDLE. `cmd_ready` stays 0 until IDLE.
- Responses seen in IDLE, REQ or RESP are stray and are discarded with no state change.
- One transaction is outstanding at most. Back-to-back throughput is 4 cycles per command with a 1-cycle-latency responder and `rsp_ready` tied high.
- Timeout (when enabled):
  - The 16-bit counter clears on entry to REQ and increments every cycle in REQ and WAIT.
  - On reaching `TIMEOUT_CYCLES` the block drops `m_read`/`m_write` and goes to RESP with `rsp_timeout`=1, `rsp_status`=2'b11 and `rsp_readdata`=0.
  - A late response arriving afterwards is stray.
- Reset mid-operation: all outputs return to their reset values immediately and the in-flight transaction is abandoned.

## Timing
- Reset values:
  - `cmd_ready`=1.
  - `rsp_valid`, `rsp_timeout`, `m_read`, `m_write` and `busy` = 0.
  - `rsp_readdata`=0, `rsp_status`=0, `m_address`=0, `m_writedata`=0, `m_byteenable`=0.
  - `m_burstcount`=1.
- All `m_*` and `rsp_*` outputs are registered. `cmd_ready` and `busy` are decoded from the state register.
- Command accepted at edge N → `m_read`/`m_write` high from N+1.
- Bus accepts at edge M (waitrequest low) → request low from M+1.
- Response valid sampled at edge K → `rsp_valid` high from K+1.
- `rsp_valid` and `rsp_ready` both high at edge R → `cmd_ready` high from R+1.

## Configuration
- `BUS_MASTER_TIMEOUT_EN` defined: the timeout counter and abort path are compiled in.
- Not defined: no counter exists, the block waits indefinitely, and `rsp_timeout` is constant 0.

## Structure
- Shared package `bus_pkg`:
  - response code enum (OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11);
  - FSM state enum;
  - `BUS_ADDR_W`=30 and `BUS_DATA_W`=32;
  - SPART base word address 30'h3E00000.
- No sub-module. The timeout counter is inline under the macro.

## Test plan
- Read with SPART-style 1-cycle responder: command read 30'h3E00010, responder returns 32'h0100_0000 → `rsp_readdata`=32'h0100_0000, `rsp_status`=0, first `rsp_valid` 3 cycles after command acceptance.
- Write with waitrequest held 3 cycles: write 32'h4100_0000 to 30'h3E00011, byteenable 4'h8 → `m_write` high exactly 4 cycles with stable fields, then `rsp_valid` with `rsp_readdata`=0.
- Response back-pressure: `rsp_ready` low 5 cycles → `rsp_valid` and data held, `cmd_ready` stays 0, and the next command is accepted only after the handshake.
- Stray `m_readdatavalid` pulses in IDLE and during a write's WAIT → ignored; the write still completes on `m_writeresponsevalid`.
- Timeout (macro on, `TIMEOUT_CYCLES`=8): responder never answers → `rsp_timeout`=1, `rsp_status`=2'b11, `rsp_readdata`=0. A later late response is ignored.
- `rst_n` asserted during WAIT → `m_read`/`m_write`/`rsp_valid` = 0 and `cmd_ready`=1 immediately, with no response emitted after release.
